// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_pkg
//  Description : Shared constants for the MEM pipeline stage: memory opcodes,
//                FSM state codes, byte-select width, NOP register address and
//                the misaligned-address exception code.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    // Memory opcodes (aluop encodings coming out of ex_mem)
    localparam logic [7:0] c_OP_LB  = 8'b11100000;
    localparam logic [7:0] c_OP_LBU = 8'b11100100;
    localparam logic [7:0] c_OP_LH  = 8'b11100001;
    localparam logic [7:0] c_OP_LHU = 8'b11100101;
    localparam logic [7:0] c_OP_LW  = 8'b11100011;
    localparam logic [7:0] c_OP_SB  = 8'b11101000;
    localparam logic [7:0] c_OP_SH  = 8'b11101001;
    localparam logic [7:0] c_OP_SW  = 8'b11101011;

    // FSM state codes
    localparam int         c_ST_W    = 2;
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Byte-select bus width (bit3 = bits[31:24])
    localparam int         c_DBUS_SEL_W = 4;

    // Register address written when nothing is to be written back
    localparam logic [4:0] c_NOP_REG_ADDR = 5'd0;

    // Level driven on excp_ade for a misaligned access
    localparam logic       c_EXCP_ADE = 1'b1;

endpackage : mem_access_pkg
`default_nettype wire

// File: rtl/mem_lane.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane
//  Description : Purely combinational byte-lane unit for the MEM stage.
//                Decodes the memory opcode, produces big-endian byte enables,
//                lane-replicated store data, sign/zero-extended load data and
//                the misalignment flag.
//  Ports       : i_aluop      - operation code
//                i_addr_lo    - effective address bits [1:0]
//                i_reg2       - store data
//                i_rdata      - bus read data
//                o_mem_op     - opcode is a load or store
//                o_load       - opcode is a load
//                o_misaligned - access violates natural alignment
//                o_sel        - byte enables
//                o_wdata      - replicated store data
//                o_ldata      - extended load result
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lane
    import mem_access_pkg::*;
(
    input  logic [7:0]              i_aluop,
    input  logic [1:0]              i_addr_lo,
    input  logic [31:0]             i_reg2,
    input  logic [31:0]             i_rdata,
    output logic                    o_mem_op,
    output logic                    o_load,
    output logic                    o_misaligned,
    output logic [c_DBUS_SEL_W-1:0] o_sel,
    output logic [31:0]             o_wdata,
    output logic [31:0]             o_ldata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Big-endian lane pick: address 0 is the most significant byte
    always_comb begin
        w_byte = 8'd0;
        case (i_addr_lo)
            2'b00:   w_byte = i_rdata[31:24];
            2'b01:   w_byte = i_rdata[23:16];
            2'b10:   w_byte = i_rdata[15:8];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[15:0] : i_rdata[31:16];
    end

    always_comb begin
        o_mem_op     = 1'b0;
        o_load       = 1'b0;
        o_misaligned = 1'b0;
        o_sel        = '0;
        o_wdata      = 32'd0;
        o_ldata      = 32'd0;
        case (i_aluop)
            c_OP_LB, c_OP_LBU, c_OP_SB: begin
                o_mem_op = 1'b1;
                o_load   = (i_aluop != c_OP_SB);
                case (i_addr_lo)
                    2'b00:   o_sel = 4'b1000;
                    2'b01:   o_sel = 4'b0100;
                    2'b10:   o_sel = 4'b0010;
                    default: o_sel = 4'b0001;
                endcase
                o_wdata = {4{i_reg2[7:0]}};
                if (i_aluop == c_OP_LB)
                    o_ldata = {{24{w_byte[7]}}, w_byte};
                else
                    o_ldata = {24'd0, w_byte};
            end
            c_OP_LH, c_OP_LHU, c_OP_SH: begin
                o_mem_op     = 1'b1;
                o_load       = (i_aluop != c_OP_SH);
                o_misaligned = i_addr_lo[0];
                o_sel        = i_addr_lo[1] ? 4'b0011 : 4'b1100;
                o_wdata      = {2{i_reg2[15:0]}};
                if (i_aluop == c_OP_LH)
                    o_ldata = {{16{w_half[15]}}, w_half};
                else
                    o_ldata = {16'd0, w_half};
            end
            c_OP_LW, c_OP_SW: begin
                o_mem_op     = 1'b1;
                o_load       = (i_aluop == c_OP_LW);
                o_misaligned = (i_addr_lo != 2'b00);
                o_sel        = 4'b1111;
                o_wdata      = i_reg2;
                o_ldata      = i_rdata;
            end
            default: ;
        endcase
    end

endmodule : mem_lane
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access
//  Description : MEM stage of the five-stage pipeline. Runs loads/stores over
//                a word-wide req/ack data bus, stalling the pipeline until the
//                access completes; non-memory ops pass straight through.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                i_wd/i_wreg/i_wdata- write-back triple from ex_mem
//                i_aluop            - operation code
//                i_mem_addr, i_reg2 - effective address, store data
//                mem_wd/wreg/wdata  - write-back triple to mem_wb
//                stallreq           - hold request to pipeline control
//                excp_ade           - misaligned address exception
//                dbus_*             - registered data-bus request fields,
//                                     dbus_rdata/dbus_ack returned by the bus
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access
    import mem_access_pkg::*;
#(
    parameter int DBUS_AW = 32   // 3..32; low 2 bits always driven 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4:0]              i_wd,
    input  logic                    i_wreg,
    input  logic [31:0]             i_wdata,
    input  logic [7:0]              i_aluop,
    input  logic [31:0]             i_mem_addr,
    input  logic [31:0]             i_reg2,
    output logic [4:0]              mem_wd,
    output logic                    mem_wreg,
    output logic [31:0]             mem_wdata,
    output logic                    stallreq,
    output logic                    excp_ade,
    output logic                    dbus_req,
    output logic                    dbus_we,
    output logic [DBUS_AW-1:0]      dbus_addr,
    output logic [c_DBUS_SEL_W-1:0] dbus_sel,
    output logic [31:0]             dbus_wdata,
    input  logic [31:0]             dbus_rdata,
    input  logic                    dbus_ack
);

    logic [c_ST_W-1:0]       r_state;
    logic                    r_dbus_req;
    logic                    r_dbus_we;
    logic [DBUS_AW-1:0]      r_dbus_addr;
    logic [c_DBUS_SEL_W-1:0] r_dbus_sel;
    logic [31:0]             r_dbus_wdata;
    logic [31:0]             r_rdata_q;

    logic                    w_mem_op;
    logic                    w_load;
    logic                    w_misaligned;
    logic [c_DBUS_SEL_W-1:0] w_sel;
    logic [31:0]             w_wdata;
    logic [31:0]             w_ldata;

    mem_lane u_mem_lane (
        .i_aluop      (i_aluop),
        .i_addr_lo    (i_mem_addr[1:0]),
        .i_reg2       (i_reg2),
        .i_rdata      (dbus_rdata),
        .o_mem_op     (w_mem_op),
        .o_load       (w_load),
        .o_misaligned (w_misaligned),
        .o_sel        (w_sel),
        .o_wdata      (w_wdata),
        .o_ldata      (w_ldata)
    );

    // Bus sequencing. ex_mem is held by ctrl for the whole access, so the
    // decoded op stays valid from IDLE through DONE; DONE always returns to
    // IDLE because the pipeline advances on that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_dbus_req   <= 1'b0;
            r_dbus_we    <= 1'b0;
            r_dbus_addr  <= '0;
            r_dbus_sel   <= '0;
            r_dbus_wdata <= 32'd0;
            r_rdata_q    <= 32'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_mem_op && !w_misaligned) begin
                        r_dbus_req   <= 1'b1;
                        r_dbus_we    <= !w_load;
                        r_dbus_addr  <= {i_mem_addr[DBUS_AW-1:2], 2'b00};
                        r_dbus_sel   <= w_sel;
                        r_dbus_wdata <= w_wdata;
                        r_state      <= c_ST_BUSY;
                    end
                end
                c_ST_BUSY: begin
                    if (dbus_ack) begin
                        r_dbus_req <= 1'b0;
                        if (w_load)
                            r_rdata_q <= w_ldata;
                        r_state <= c_ST_DONE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Write-back and stall outputs; all forced to zero while in reset
    always_comb begin
        mem_wd    = c_NOP_REG_ADDR;
        mem_wreg  = 1'b0;
        mem_wdata = 32'd0;
        stallreq  = 1'b0;
        excp_ade  = 1'b0;
        if (!rst) begin
            case (r_state)
                c_ST_IDLE: begin
                    mem_wd    = i_wd;
                    mem_wdata = i_wdata;
                    if (!w_mem_op)
                        mem_wreg = i_wreg;
                    else if (w_misaligned)
                        excp_ade = c_EXCP_ADE;
                    else
                        stallreq = 1'b1;
                end
                c_ST_BUSY: begin
                    mem_wd   = i_wd;
                    stallreq = 1'b1;
                end
                c_ST_DONE: begin
                    mem_wd    = i_wd;
                    mem_wreg  = i_wreg;
                    mem_wdata = w_load ? r_rdata_q : i_wdata;
                end
                default: ;
            endcase
        end
    end

    assign dbus_req   = r_dbus_req;
    assign dbus_we    = r_dbus_we;
    assign dbus_addr  = r_dbus_addr;
    assign dbus_sel   = r_dbus_sel;
    assign dbus_wdata = r_dbus_wdata;

endmodule : mem_access
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access
//  Description : Self-checking bench for mem_access: a table of hand-computed
//                vectors, a reset-during-BUSY sequence and randomized ops
//                checked against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;

    localparam logic [7:0] c_LB  = 8'hE0, c_LBU = 8'hE4, c_LH = 8'hE1, c_LHU = 8'hE5;
    localparam logic [7:0] c_LW  = 8'hE3, c_SB  = 8'hE8, c_SH = 8'hE9, c_SW  = 8'hEB;
    localparam logic [7:0] c_ADD = 8'h20, c_NOP = 8'h00;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  i_wd;
    logic        i_wreg;
    logic [31:0] i_wdata;
    logic [7:0]  i_aluop;
    logic [31:0] i_mem_addr;
    logic [31:0] i_reg2;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        stallreq;
    logic        excp_ade;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;

    int checks = 0;
    int errors = 0;

    mem_access #(.DBUS_AW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_wd       (i_wd),
        .i_wreg     (i_wreg),
        .i_wdata    (i_wdata),
        .i_aluop    (i_aluop),
        .i_mem_addr (i_mem_addr),
        .i_reg2     (i_reg2),
        .mem_wd     (mem_wd),
        .mem_wreg   (mem_wreg),
        .mem_wdata  (mem_wdata),
        .stallreq   (stallreq),
        .excp_ade   (excp_ade),
        .dbus_req   (dbus_req),
        .dbus_we    (dbus_we),
        .dbus_addr  (dbus_addr),
        .dbus_sel   (dbus_sel),
        .dbus_wdata (dbus_wdata),
        .dbus_rdata (dbus_rdata),
        .dbus_ack   (dbus_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  aluop;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [31:0] rdata;
        int          waits;
        logic        e_mem;
        logic        e_ade;
        logic        e_we;
        logic [3:0]  e_sel;
        logic [31:0] e_bwdata;
        logic        e_chk_res;
        logic [31:0] e_result;
    } vec_t;

    function automatic vec_t mk(
        input logic [7:0] aluop, input logic [4:0] wd, input logic wreg,
        input logic [31:0] wdata, input logic [31:0] addr, input logic [31:0] reg2,
        input logic [31:0] rdata, input int waits, input logic e_mem,
        input logic e_ade, input logic e_we, input logic [3:0] e_sel,
        input logic [31:0] e_bwdata, input logic e_chk_res, input logic [31:0] e_result);
        vec_t v;
        v.aluop = aluop; v.wd = wd; v.wreg = wreg; v.wdata = wdata;
        v.addr = addr; v.reg2 = reg2; v.rdata = rdata; v.waits = waits;
        v.e_mem = e_mem; v.e_ade = e_ade; v.e_we = e_we; v.e_sel = e_sel;
        v.e_bwdata = e_bwdata; v.e_chk_res = e_chk_res; v.e_result = e_result;
        return v;
    endfunction

    // Reference model: access size, natural alignment, big-endian lane
    // position and extension computed arithmetically.
    function automatic vec_t model(
        input logic [7:0] op, input logic [4:0] wd, input logic wreg,
        input logic [31:0] wdata, input logic [31:0] addr, input logic [31:0] reg2,
        input logic [31:0] rdata, input int waits);
        vec_t            v;
        int              size;
        int              off;
        bit              st;
        bit              sg;
        longint unsigned mask;
        longint unsigned val;
        longint unsigned lane;
        size = 0; st = 1'b0; sg = 1'b0;
        case (op)
            c_LB:  begin size = 1; sg = 1'b1; end
            c_LBU: size = 1;
            c_SB:  begin size = 1; st = 1'b1; end
            c_LH:  begin size = 2; sg = 1'b1; end
            c_LHU: size = 2;
            c_SH:  begin size = 2; st = 1'b1; end
            c_LW:  size = 4;
            c_SW:  begin size = 4; st = 1'b1; end
            default: size = 0;
        endcase
        v = mk(op, wd, st ? 1'b0 : wreg, wdata, addr, reg2, rdata, waits,
               1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, wdata);
        if (size != 0) begin
            v.e_mem     = 1'b1;
            v.e_chk_res = 1'b0;
            off = int'(addr[1:0]);
            if (off % size != 0) begin
                v.e_ade = 1'b1;
            end else begin
                v.e_we  = st;
                v.e_sel = 4'(((1 << size) - 1) << (4 - off - size));
                mask = (64'd1 << (8 * size)) - 64'd1;
                val  = {32'd0, reg2} & mask;
                lane = 64'd0;
                for (int k = 0; k < 4 / size; k++)
                    lane = lane | (val << (8 * size * k));
                v.e_bwdata = lane[31:0];
                val = ({32'd0, rdata} >> (8 * (4 - off - size))) & mask;
                if (sg && val[8 * size - 1])
                    val = val | ~mask;
                v.e_chk_res = !st;
                v.e_result  = val[31:0];
            end
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Present one op and follow it through to completion, driving the bus ack
    // after v.waits wait cycles.
    task automatic run_op(input vec_t v);
        @(posedge clk); #1;
        i_aluop = v.aluop; i_wd = v.wd; i_wreg = v.wreg; i_wdata = v.wdata;
        i_mem_addr = v.addr; i_reg2 = v.reg2;
        dbus_ack = 1'($urandom_range(0, 1));   // stray ack while IDLE
        dbus_rdata = $urandom;
        @(negedge clk);
        chk("idle_req", dbus_req, 0);
        if (!v.e_mem) begin
            chk("pass_wd", mem_wd, v.wd);
            chk("pass_wreg", mem_wreg, v.wreg);
            chk("pass_wdata", mem_wdata, v.e_result);
            chk("pass_stall", stallreq, 0);
            chk("pass_ade", excp_ade, 0);
        end else if (v.e_ade) begin
            chk("ade_flag", excp_ade, 1);
            chk("ade_wreg", mem_wreg, 0);
            chk("ade_stall", stallreq, 0);
        end else begin
            chk("issue_stall", stallreq, 1);
            chk("issue_wreg", mem_wreg, 0);
            chk("issue_ade", excp_ade, 0);
            for (int k = 0; k <= v.waits; k++) begin
                @(posedge clk); #1;
                dbus_ack   = (k == v.waits);
                dbus_rdata = (k == v.waits) ? v.rdata : $urandom;
                @(negedge clk);
                chk("busy_req", dbus_req, 1);
                chk("busy_stall", stallreq, 1);
                chk("busy_wreg", mem_wreg, 0);
                chk("busy_addr", dbus_addr, {v.addr[31:2], 2'b00});
                chk("busy_sel", dbus_sel, v.e_sel);
                chk("busy_we", dbus_we, v.e_we);
                if (v.e_we)
                    chk("busy_bwdata", dbus_wdata, v.e_bwdata);
            end
            @(posedge clk); #1;
            dbus_ack = 1'b0; dbus_rdata = $urandom;
            @(negedge clk);
            chk("done_req", dbus_req, 0);
            chk("done_stall", stallreq, 0);
            chk("done_wd", mem_wd, v.wd);
            chk("done_wreg", mem_wreg, v.wreg);
            if (v.e_chk_res)
                chk("done_wdata", mem_wdata, v.e_result);
        end
    endtask

    vec_t       vecs[15];
    logic [7:0] ops[10];

    initial begin
        // Hand-computed vectors
        vecs[0]  = mk(c_ADD, 5'd5,  1'b1, 32'h1234, 32'h0,   32'h0,         32'h0,         0, 0, 0, 0, 4'b0000, 32'h0,         1, 32'h1234);
        vecs[1]  = mk(c_LB,  5'd3,  1'b1, 32'h0,    32'h101, 32'h0,         32'h11F0_3344, 0, 1, 0, 0, 4'b0100, 32'h0,         1, 32'hFFFF_FFF0);
        vecs[2]  = mk(c_SH,  5'd0,  1'b0, 32'h0,    32'h202, 32'hAAAA_BEEF, 32'h0,         3, 1, 0, 1, 4'b0011, 32'hBEEF_BEEF, 0, 32'h0);
        vecs[3]  = mk(c_LW,  5'd7,  1'b1, 32'h0,    32'h306, 32'h0,         32'h0,         0, 1, 1, 0, 4'b0000, 32'h0,         0, 32'h0);
        vecs[4]  = mk(c_LHU, 5'd8,  1'b1, 32'h0,    32'h400, 32'h0,         32'h8001_0000, 0, 1, 0, 0, 4'b1100, 32'h0,         1, 32'h0000_8001);
        vecs[5]  = mk(c_LW,  5'd9,  1'b1, 32'h0,    32'h500, 32'h0,         32'hDEAD_BEEF, 1, 1, 0, 0, 4'b1111, 32'h0,         1, 32'hDEAD_BEEF);
        vecs[6]  = mk(c_LBU, 5'd10, 1'b1, 32'h0,    32'h103, 32'h0,         32'h1234_56F7, 2, 1, 0, 0, 4'b0001, 32'h0,         1, 32'h0000_00F7);
        vecs[7]  = mk(c_LH,  5'd11, 1'b1, 32'h0,    32'h102, 32'h0,         32'h0000_8123, 0, 1, 0, 0, 4'b0011, 32'h0,         1, 32'hFFFF_8123);
        vecs[8]  = mk(c_SB,  5'd0,  1'b0, 32'h0,    32'h001, 32'h1234_565A, 32'h0,         0, 1, 0, 1, 4'b0100, 32'h5A5A_5A5A, 0, 32'h0);
        vecs[9]  = mk(c_SW,  5'd0,  1'b0, 32'h0,    32'h008, 32'hCAFE_F00D, 32'h0,         1, 1, 0, 1, 4'b1111, 32'hCAFE_F00D, 0, 32'h0);
        vecs[10] = mk(c_LH,  5'd12, 1'b1, 32'h0,    32'h103, 32'h0,         32'h0,         0, 1, 1, 0, 4'b0000, 32'h0,         0, 32'h0);
        vecs[11] = mk(c_SH,  5'd0,  1'b0, 32'h0,    32'h201, 32'h0,         32'h0,         0, 1, 1, 0, 4'b0000, 32'h0,         0, 32'h0);
        vecs[12] = mk(c_SW,  5'd0,  1'b0, 32'h0,    32'h002, 32'h0,         32'h0,         0, 1, 1, 0, 4'b0000, 32'h0,         0, 32'h0);
        vecs[13] = mk(c_LB,  5'd13, 1'b1, 32'h0,    32'h100, 32'h0,         32'h7F00_0000, 0, 1, 0, 0, 4'b1000, 32'h0,         1, 32'h0000_007F);
        vecs[14] = mk(8'hE2, 5'd31, 1'b1, 32'hFFFF_FFFF, 32'h3, 32'h0,      32'h0,         0, 0, 0, 0, 4'b0000, 32'h0,         1, 32'hFFFF_FFFF);

        ops[0] = c_LB; ops[1] = c_LBU; ops[2] = c_LH; ops[3] = c_LHU; ops[4] = c_LW;
        ops[5] = c_SB; ops[6] = c_SH;  ops[7] = c_SW; ops[8] = c_ADD; ops[9] = 8'h7A;

        // Reset state, with non-zero inputs to show outputs are forced low
        rst = 1'b1;
        i_aluop = c_ADD; i_wd = 5'd17; i_wreg = 1'b1; i_wdata = 32'h5555_AAAA;
        i_mem_addr = 32'h0; i_reg2 = 32'h0; dbus_rdata = 32'h0; dbus_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", dbus_req, 0);
        chk("rst_we", dbus_we, 0);
        chk("rst_addr", dbus_addr, 0);
        chk("rst_sel", dbus_sel, 0);
        chk("rst_bwdata", dbus_wdata, 0);
        chk("rst_wd", mem_wd, 0);
        chk("rst_wreg", mem_wreg, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_stall", stallreq, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (vecs[i])
            run_op(vecs[i]);

        // Reset while BUSY: request must drop and a late ack must be ignored
        @(posedge clk); #1;
        i_aluop = c_LW; i_wd = 5'd12; i_wreg = 1'b1; i_wdata = 32'h0;
        i_mem_addr = 32'h600; dbus_ack = 1'b0;
        @(negedge clk);
        chk("rb_issue_stall", stallreq, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rb_req_before", dbus_req, 1);
        chk("rb_forced_stall", stallreq, 0);
        chk("rb_forced_wd", mem_wd, 0);
        chk("rb_forced_wreg", mem_wreg, 0);
        chk("rb_forced_ade", excp_ade, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        i_aluop = c_NOP; i_wd = 5'd0; i_wreg = 1'b0; i_wdata = 32'h0;
        dbus_ack = 1'b1; dbus_rdata = $urandom;
        @(negedge clk);
        chk("rb_req_after", dbus_req, 0);
        chk("rb_stall_after", stallreq, 0);
        chk("rb_wreg_after", mem_wreg, 0);
        @(posedge clk); #1;
        dbus_ack = 1'b0;
        @(negedge clk);
        chk("rb_late_req", dbus_req, 0);
        chk("rb_late_stall", stallreq, 0);
        chk("rb_late_wreg", mem_wreg, 0);

        // Randomized ops against the reference model
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 0)
                a[1:0] = 2'b00;
            run_op(model(ops[$urandom_range(0, 9)], 5'($urandom), 1'($urandom),
                         $urandom, a, $urandom, $urandom, int'($urandom_range(0, 3))));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_access
`default_nettype wire
